// File: rtl/conv_window_sequencer.sv
// -----------------------------------------------------------------------------
// conv_window_sequencer
//
// Controller for the 6-lane signed 8x8 multiply stage. It scans a KSIZE x KSIZE
// kernel over an IMG_H x IMG_W feature map in row-major window order. For each
// window it issues the kernel taps six per cycle ("passes"), accumulates the
// returned 16-bit products into one signed sum, and offers the sum downstream
// over a valid/ready handshake.
//
// Optional build macro: CONV_RELU_EN. When it is defined, negative window sums
// are clamped to zero on their way into result_data. The raw accumulator is
// not affected.
//
// Ports:
//   clk          clock, all logic on the rising edge
//   reset        asynchronous active-high reset, clears all state
//   start        one-cycle pulse, starts a full-map scan when idle
//   busy         high while a scan is in progress
//   done         one-cycle pulse after the last result is accepted
//   win_row      top row of the current window
//   win_col      left column of the current window
//   pass_idx     current pass; lane l carries tap pass_idx*6+l
//   lane_valid   per-lane tap-valid mask for the current pass
//   mul_enable   multiply-stage enable, high only in issue cycles
//   prod_flat    six signed 16-bit products, lane l at [16l+15:16l]
//   result_data  signed window sum
//   result_valid result_data is valid
//   result_ready downstream accepts the result when valid & ready
// -----------------------------------------------------------------------------
module conv_window_sequencer #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int KSIZE = 3,
    parameter int ACC_W = 24
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [7:0]              win_row,
    output logic [7:0]              win_col,
    output logic [3:0]              pass_idx,
    output logic [5:0]              lane_valid,
    output logic                    mul_enable,
    input  logic [95:0]             prod_flat,
    output logic signed [ACC_W-1:0] result_data,
    output logic                    result_valid,
    input  logic                    result_ready
);

    localparam int TAPS   = KSIZE * KSIZE;
    localparam int PASSES = (TAPS + 5) / 6;

    localparam logic [7:0] COL_LAST  = 8'(IMG_W - KSIZE);
    localparam logic [7:0] ROW_LAST  = 8'(IMG_H - KSIZE);
    localparam logic [3:0] PASS_LAST = 4'(PASSES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    // A lane is valid when the tap it carries exists in the kernel.
    function automatic logic [5:0] lane_mask(input logic [3:0] p);
        logic [5:0] m;
        for (int l = 0; l < 6; l++) begin
            m[l] = ((int'(p) * 6 + l) < TAPS);
        end
        return m;
    endfunction

    // Sum of the sign-extended products of the lanes selected by mask.
    function automatic logic signed [ACC_W-1:0] lane_sum(input logic [95:0] prod,
                                                         input logic [5:0]  mask);
        logic signed [ACC_W-1:0] s;
        logic signed [15:0]      lane;
        s = '0;
        for (int l = 0; l < 6; l++) begin
            lane = prod[16*l +: 16];
            if (mask[l]) begin
                s = s + ACC_W'(lane);
            end
        end
        return s;
    endfunction

    function automatic logic signed [ACC_W-1:0] shape_result(input logic signed [ACC_W-1:0] v);
`ifdef CONV_RELU_EN
        return (v < 0) ? '0 : v;
`else
        return v;
`endif
    endfunction

    state_t                  state_q, state_d;
    logic [3:0]              pass_q, pass_d;
    logic                    drain_q, drain_d;
    logic [7:0]              row_q, row_d;
    logic [7:0]              col_q, col_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] res_q, res_d;
    logic                    done_q, done_d;
    logic                    vld_p1_q, vld_p1_d;
    logic                    vld_p2_q, vld_p2_d;
    logic [5:0]              msk_p1_q, msk_p1_d;
    logic [5:0]              msk_p2_q, msk_p2_d;

    logic                    start_ok;
    logic                    handshake;
    logic                    last_win;
    logic signed [ACC_W-1:0] acc_sum;

    // A start arriving in the done cycle is dropped so that the end of one
    // scan never overlaps the acceptance of the next.
    assign start_ok  = (state_q == S_IDLE) && start && !done_q;
    assign handshake = (state_q == S_OUT) && result_ready;
    assign last_win  = (row_q == ROW_LAST) && (col_q == COL_LAST);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_ok) state_d = S_ISSUE;
            S_ISSUE: if (pass_q == PASS_LAST) state_d = S_DRAIN;
            S_DRAIN: if (drain_q) state_d = S_OUT;
            S_OUT:   if (result_ready) state_d = last_win ? S_IDLE : S_ISSUE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy         = (state_q != S_IDLE);
        mul_enable   = (state_q == S_ISSUE);
        lane_valid   = mul_enable ? lane_mask(pass_q) : 6'b0;
        result_valid = (state_q == S_OUT);
        done         = done_q;
        win_row      = row_q;
        win_col      = col_q;
        pass_idx     = pass_q;
        result_data  = res_q;
    end

    // Counters, product alignment pipe and accumulator
    always_comb begin
        pass_d   = pass_q;
        drain_d  = drain_q;
        row_d    = row_q;
        col_d    = col_q;
        res_d    = res_q;
        done_d   = 1'b0;

        // Products come back two cycles after their pass was issued
        // (one cycle buffer read, one cycle multiply).
        vld_p1_d = mul_enable;
        msk_p1_d = lane_valid;
        vld_p2_d = vld_p1_q;
        msk_p2_d = msk_p1_q;

        acc_sum = acc_q;
        if (vld_p2_q) begin
            acc_sum = acc_q + lane_sum(prod_flat, msk_p2_q);
        end
        acc_d = acc_sum;

        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    row_d  = '0;
                    col_d  = '0;
                    pass_d = '0;
                    acc_d  = '0;
                end
            end
            S_ISSUE: begin
                pass_d  = (pass_q == PASS_LAST) ? 4'd0 : pass_q + 4'd1;
                drain_d = 1'b0;
            end
            S_DRAIN: begin
                drain_d = ~drain_q;
                // The last product lands on this edge, so latch the updated sum.
                if (drain_q) begin
                    res_d = shape_result(acc_sum);
                end
            end
            S_OUT: begin
                if (handshake) begin
                    if (last_win) begin
                        done_d = 1'b1;
                    end else begin
                        acc_d = '0;
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            row_d = row_q + 8'd1;
                        end else begin
                            col_d = col_q + 8'd1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pass_q   <= '0;
            drain_q  <= 1'b0;
            row_q    <= '0;
            col_q    <= '0;
            acc_q    <= '0;
            res_q    <= '0;
            done_q   <= 1'b0;
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            msk_p1_q <= '0;
            msk_p2_q <= '0;
        end else begin
            pass_q   <= pass_d;
            drain_q  <= drain_d;
            row_q    <= row_d;
            col_q    <= col_d;
            acc_q    <= acc_d;
            res_q    <= res_d;
            done_q   <= done_d;
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            msk_p1_q <= msk_p1_d;
            msk_p2_q <= msk_p2_d;
        end
    end

endmodule

// File: tb/tb_conv_window_sequencer.sv
module tb_conv_window_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Small 4x4 instance
    logic               reset, start, result_ready;
    logic               busy, done, mul_enable, result_valid;
    logic [7:0]         win_row, win_col;
    logic [3:0]         pass_idx;
    logic [5:0]         lane_valid;
    logic [95:0]        prod_flat;
    logic signed [23:0] result_data;

    // Default 28x28 instance
    logic               reset_l, start_l;
    logic               busy_l, done_l, mul_enable_l, result_valid_l;
    logic [7:0]         win_row_l, win_col_l;
    logic [3:0]         pass_idx_l;
    logic [5:0]         lane_valid_l;
    logic signed [23:0] result_data_l;
    logic [95:0]        prod_flat_l;
    logic               result_ready_l;

    conv_window_sequencer #(.IMG_W(4), .IMG_H(4), .KSIZE(3), .ACC_W(24)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .win_row(win_row), .win_col(win_col), .pass_idx(pass_idx),
        .lane_valid(lane_valid), .mul_enable(mul_enable), .prod_flat(prod_flat),
        .result_data(result_data), .result_valid(result_valid),
        .result_ready(result_ready)
    );

    conv_window_sequencer dut_l (
        .clk(clk), .reset(reset_l), .start(start_l), .busy(busy_l), .done(done_l),
        .win_row(win_row_l), .win_col(win_col_l), .pass_idx(pass_idx_l),
        .lane_valid(lane_valid_l), .mul_enable(mul_enable_l), .prod_flat(prod_flat_l),
        .result_data(result_data_l), .result_valid(result_valid_l),
        .result_ready(result_ready_l)
    );

    assign prod_flat_l    = {6{16'h0001}};
    assign result_ready_l = 1'b1;

    int checks   = 0;
    int failures = 0;
    int mode     = 0;

`ifdef CONV_RELU_EN
    localparam logic signed [63:0] NEG_ONE_EXP = 64'sd0;
`else
    localparam logic signed [63:0] NEG_ONE_EXP = -64'sd9;
`endif

    // Multiply-stage model: products appear two cycles after their pass issues.
    logic       tv1, tv2;
    logic [3:0] tp1, tp2;
    always @(posedge clk) begin
        tv1 <= mul_enable;
        tp1 <= pass_idx;
        tv2 <= tv1;
        tp2 <= tp1;
    end

    always_comb begin
        prod_flat = {6{16'h7FFF}};
        if (tv2 === 1'b1) begin
            case (mode)
                0:       prod_flat = {6{16'h0001}};
                1:       prod_flat = (tp2 == 4'd1) ? {{3{16'h7FFF}}, {3{16'hFFFE}}}
                                                   : {6{16'hFFFE}};
                default: prod_flat = {6{16'hFFFF}};
            endcase
        end
    end

    int done_cnt = 0;
    int done_cnt_l = 0;
    int res_cnt_l = 0;
    longint sum_l = 0;
    always @(posedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (done_l === 1'b1) done_cnt_l <= done_cnt_l + 1;
        if (result_valid_l === 1'b1 && result_ready_l) begin
            res_cnt_l <= res_cnt_l + 1;
            sum_l     <= sum_l + longint'(result_data_l);
        end
    end

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_row"}, win_row, 0);
        chk({tag, "_col"}, win_col, 0);
        chk({tag, "_pass"}, pass_idx, 0);
        chk({tag, "_mask"}, lane_valid, 0);
        chk({tag, "_mulen"}, mul_enable, 0);
        chk({tag, "_data"}, result_data, 0);
        chk({tag, "_rvalid"}, result_valid, 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Follows one window from its first issue cycle to its OUT cycle.
    task automatic scan_window(input string tag, input int er, input int ec,
                               input logic signed [63:0] ed, input bit advance);
        int n;
        bit found;
        n = 0;
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (mul_enable === 1'b1) begin
                chk({tag, "_pass"}, pass_idx, n);
                chk({tag, "_mask"}, lane_valid, (n == 0) ? 6'h3F : 6'h07);
                n++;
            end
            if (result_valid === 1'b1) begin
                found = 1;
                chk({tag, "_row"}, win_row, er);
                chk({tag, "_col"}, win_col, ec);
                chk({tag, "_data"}, result_data, ed);
                chk({tag, "_issues"}, n, 2);
            end else begin
                @(negedge clk);
            end
        end
        if (!found) chk({tag, "_timeout"}, 0, 1);
        else if (advance) @(negedge clk);
    endtask

    initial begin
        int base;
        bit found;
        reset = 1'b1; start = 1'b0; result_ready = 1'b1;
        reset_l = 1'b1; start_l = 1'b0;

        // Reset state
        @(negedge clk);
        chk_reset_vals("rst");
        #2 reset = 1'b0; reset_l = 1'b0;
        @(negedge clk);

        // All lanes 1: four results of 9 in row-major order, one done pulse
        mode = 0;
        base = done_cnt;
        pulse_start();
        chk("t1_busy", busy, 1);
        scan_window("t1_w0", 0, 0, 9, 1);
        scan_window("t1_w1", 0, 1, 9, 1);
        scan_window("t1_w2", 1, 0, 9, 1);
        scan_window("t1_w3", 1, 1, 9, 1);
        chk("t1_done", done, 1);
        chk("t1_busy_end", busy, 0);
        @(negedge clk);
        chk("t1_done_clr", done, 0);
        chk("t1_done_cnt", done_cnt - base, 1);

        // Masked lanes carry 0x7FFF, valid lanes -2: each result -18
        mode = 1;
        pulse_start();
        scan_window("t2_w0", 0, 0, -18, 1);
        scan_window("t2_w1", 0, 1, -18, 1);
        scan_window("t2_w2", 1, 0, -18, 1);
        scan_window("t2_w3", 1, 1, -18, 1);
        @(negedge clk);

        // Backpressure for 10 cycles on window (0,1)
        mode = 0;
        pulse_start();
        scan_window("t3_w0", 0, 0, 9, 1);
        result_ready = 1'b0;
        scan_window("t3_w1", 0, 1, 9, 0);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("t3_hold_valid", result_valid, 1);
            chk("t3_hold_data", result_data, 9);
            chk("t3_hold_mulen", mul_enable, 0);
            chk("t3_hold_row", win_row, 0);
            chk("t3_hold_col", win_col, 1);
        end
        result_ready = 1'b1;
        @(negedge clk);
        chk("t3_rel_mulen", mul_enable, 1);
        chk("t3_rel_row", win_row, 1);
        chk("t3_rel_col", win_col, 0);
        scan_window("t3_w2", 1, 0, 9, 1);
        scan_window("t3_w3", 1, 1, 9, 1);
        chk("t3_done", done, 1);
        @(negedge clk);

        // Reset during ISSUE of the third window
        pulse_start();
        scan_window("t4_w0", 0, 0, 9, 1);
        scan_window("t4_w1", 0, 1, 9, 1);
        chk("t4_in_issue", mul_enable, 1);
        base = done_cnt;
        reset = 1'b1;
        #1;
        chk_reset_vals("t4_async");
        #2 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t4_no_done", done_cnt - base, 0);
        chk("t4_idle", busy, 0);
        pulse_start();
        scan_window("t4_r0", 0, 0, 9, 1);
        scan_window("t4_r1", 0, 1, 9, 1);
        scan_window("t4_r2", 1, 0, 9, 1);
        scan_window("t4_r3", 1, 1, 9, 1);
        @(negedge clk);

        // All lanes -1: -9 raw, 0 with ReLU
        mode = 2;
        pulse_start();
        scan_window("t5_w0", 0, 0, NEG_ONE_EXP, 1);
        scan_window("t5_w1", 0, 1, NEG_ONE_EXP, 1);
        scan_window("t5_w2", 1, 0, NEG_ONE_EXP, 1);
        scan_window("t5_w3", 1, 1, NEG_ONE_EXP, 1);
        @(negedge clk);

        // Default 28x28 map with stray start pulses while busy: 676 results
        start_l = 1'b1;
        @(negedge clk);
        start_l = 1'b0;
        found = 0;
        for (int c = 0; c < 4000 && !found; c++) begin
            @(negedge clk);
            start_l = (c == 3 || c == 100 || c == 2000);
            if (done_l === 1'b1) found = 1;
        end
        start_l = 1'b0;
        chk("t6_done_seen", found, 1);
        chk("t6_results", res_cnt_l, 676);
        chk("t6_sum", sum_l, 676 * 9);
        @(negedge clk);
        chk("t6_done_cnt", done_cnt_l, 1);
        chk("t6_idle", busy_l, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
